// File: rtl/rram_pkg.sv
// rtl/rram_pkg.sv - shared encodings for the RRAM pulse sequencer
package rram_pkg;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_SET   = 2'd1,
    OP_RESET = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_SENSE = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5,
    S_RESP  = 3'd6
  } state_e;

  // Index to one-hot line select for the 16-line array edges.
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

endpackage

// File: rtl/rram_phase_timer.sv
// rtl/rram_phase_timer.sv - loadable down-counter timing each sequencer phase
module rram_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/rram_pulse_sequencer.sv
// rtl/rram_pulse_sequencer.sv - WL/BL pulse-train sequencer with read-verify for the 1T1R array
module rram_pulse_sequencer
  import rram_pkg::*;
#(
  parameter int T_SETUP   = 2,
  parameter int T_PULSE   = 8,
  parameter int T_SENSE   = 4,
  parameter int T_HOLD    = 2,
  parameter int T_GAP     = 4,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [3:0]      cmd_row,
  input  logic [3:0]      cmd_col,
  input  logic            cmd_verify,
  output logic [ROWS-1:0] wl,
  output logic [COLS-1:0] bl,
  output logic            rst_pol,
  input  logic [COLS-1:0] sl,
  output logic            rsp_valid,
  output logic [COLS-1:0] rsp_data,
  output logic            rsp_ok,
  output logic            rsp_err,
  output logic [3:0]      rsp_tries,
  output logic            busy
);

  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PULSE  = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_SENSE  = CNT_W'(T_SENSE - 1);
  localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(T_GAP - 1);
  localparam logic [3:0]       MAX_TRIES = 4'(MAX_RETRY);

  state_e           state, state_d;
  op_e              op_q;
  logic [3:0]       row_q, col_q;
  logic             verify_q;
  logic             vphase_q;   // 1 while running the read-verify pass of a program op
  logic [3:0]       tries_q;
  logic [COLS-1:0]  sense_q;
  logic             pass_q;
  logic             accept;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             is_prog;
  logic             final_ok;

  assign accept   = cmd_valid && cmd_ready && (state == S_IDLE);
  assign is_prog  = (op_q == OP_SET) || (op_q == OP_RESET);
  assign final_ok = (op_q != OP_RSVD) && (!(is_prog && verify_q) || pass_q);

  rram_phase_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Next-state logic; every phase entry reloads the shared timer.
  always_comb begin
    state_d  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP; tmr_load = 1'b1; tmr_val = LD_SETUP;
        end
      end
      S_SETUP: begin
        if (op_q == OP_RSVD) begin
          state_d = S_RESP;
        end else if (tmr_done) begin
          tmr_load = 1'b1;
          if (op_q == OP_READ || vphase_q) begin
            state_d = S_SENSE; tmr_val = LD_SENSE;
          end else begin
            state_d = S_PULSE; tmr_val = LD_PULSE;
          end
        end
      end
      S_PULSE, S_SENSE: begin
        if (tmr_done) begin
          state_d = S_HOLD; tmr_load = 1'b1; tmr_val = LD_HOLD;
        end
      end
      S_HOLD: begin
        if (tmr_done) begin
          state_d = S_GAP; tmr_load = 1'b1; tmr_val = LD_GAP;
        end
      end
      S_GAP: begin
        if (tmr_done) begin
          if (op_q == OP_READ) begin
            state_d = S_RESP;
          end else if (!vphase_q) begin
            if (verify_q) begin
              state_d = S_SETUP; tmr_load = 1'b1; tmr_val = LD_SETUP;
            end else begin
              state_d = S_RESP;
            end
          end else if (pass_q || tries_q >= MAX_TRIES) begin
            state_d = S_RESP;
          end else begin
            state_d = S_SETUP; tmr_load = 1'b1; tmr_val = LD_SETUP;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch, sense capture and retry bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_READ;
      row_q    <= '0;
      col_q    <= '0;
      verify_q <= 1'b0;
      vphase_q <= 1'b0;
      tries_q  <= '0;
      sense_q  <= '0;
      pass_q   <= 1'b0;
    end else if (accept) begin
      op_q     <= op_e'(cmd_op);
      row_q    <= cmd_row;
      col_q    <= cmd_col;
      verify_q <= cmd_verify;
      vphase_q <= 1'b0;
      tries_q  <= (cmd_op == OP_SET || cmd_op == OP_RESET) ? 4'd1 : 4'd0;
      sense_q  <= '0;
      pass_q   <= 1'b0;
    end else if (state == S_SENSE && tmr_done) begin
      sense_q <= sl;
      pass_q  <= (sl[col_q] == (op_q == OP_SET));
    end else if (state == S_GAP && tmr_done && is_prog) begin
      if (!vphase_q) begin
        vphase_q <= verify_q;
      end else if (!pass_q && tries_q < MAX_TRIES) begin
        vphase_q <= 1'b0;
        tries_q  <= tries_q + 4'd1;
      end
    end
  end

  // Registered array drive and response outputs, decoded from the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      wl        <= '0;
      bl        <= '0;
      rst_pol   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_ok    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_tries <= '0;
    end else begin
      cmd_ready <= (state == S_IDLE) && !accept;
      busy      <= (state != S_IDLE);
      wl        <= '0;
      bl        <= '0;
      rst_pol   <= 1'b0;
      rsp_valid <= 1'b0;
      if ((state inside {S_SETUP, S_PULSE, S_SENSE, S_HOLD}) && op_q != OP_RSVD) begin
        wl <= onehot16(row_q);
      end
      if (state == S_PULSE) begin
        bl      <= onehot16(col_q);
        rst_pol <= (op_q == OP_RESET);
      end
      if (state == S_RESP) begin
        rsp_valid <= 1'b1;
        rsp_data  <= sense_q;
        rsp_ok    <= final_ok;
        rsp_err   <= !final_ok;
        rsp_tries <= tries_q;
      end
    end
  end

endmodule
